// File: rtl/led_panel_rx.sv
// led_panel_rx: receiver for a serial LED-panel row interface.
//   Samples asynchronous panel signals (R1in, Ain, clkin, latin) through
//   2-flop synchronizers, shifts colour bits in on clkin rising edges and
//   accepts a row on a latin rising edge when exactly WIDTH bits arrived.
// Ports:
//   clk, rst_n   - system clock, asynchronous active-low reset
//   R1in, Ain    - panel serial data and row-address bit (async)
//   clkin, latin - panel shift clock and latch strobe (async)
//   clr_err      - synchronous clear of the sticky error flags
//   row_data     - last accepted row, first-shifted bit in MSB
//   row_addr     - Ain captured with row_data
//   row_valid    - one-cycle pulse when row_data/row_addr update
//   frame_done   - one-cycle pulse when both row addresses were accepted
//   err_len      - sticky: latch arrived after fewer than WIDTH shifts
//   err_ovr      - sticky: more than WIDTH shifts arrived before a latch
//   latch_count  - wrapping count of all latin rising edges
module led_panel_rx #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             R1in,
    input  logic             Ain,
    input  logic             clkin,
    input  logic             latin,
    input  logic             clr_err,
    output logic [WIDTH-1:0] row_data,
    output logic             row_addr,
    output logic             row_valid,
    output logic             frame_done,
    output logic             err_len,
    output logic             err_ovr,
    output logic [CNT_W-1:0] latch_count
);

    localparam int unsigned BC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_e;

    // ---------------- synchronizers and edge detection ----------------
    logic r1_s1_q, r1_s2_q, a_s1_q, a_s2_q;
    logic ck_s1_q, ck_s2_q, ck_s3_q, lt_s1_q, lt_s2_q, lt_s3_q;
    logic r1_s1_d, r1_s2_d, a_s1_d, a_s2_d;
    logic ck_s1_d, ck_s2_d, ck_s3_d, lt_s1_d, lt_s2_d, lt_s3_d;
    logic [1:0] arm_q, arm_d;
    logic       armed, shift_evt, latch_evt;

    always_comb begin
        r1_s1_d = R1in;
        r1_s2_d = r1_s1_q;
        a_s1_d  = Ain;
        a_s2_d  = a_s1_q;
        ck_s1_d = clkin;
        ck_s2_d = ck_s1_q;
        ck_s3_d = ck_s2_q;
        lt_s1_d = latin;
        lt_s2_d = lt_s1_q;
        lt_s3_d = lt_s2_q;
        arm_d   = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
    end

    // Edges are ignored until the third cycle after reset release, when the
    // registered copy first holds a real sampled level; a clkin/latin already
    // high at release therefore never looks like a rising edge.
    assign armed     = (arm_q == 2'd3);
    assign shift_evt = armed & ck_s2_q & ~ck_s3_q;
    assign latch_evt = armed & lt_s2_q & ~lt_s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_s1_q <= 1'b0;
            r1_s2_q <= 1'b0;
            a_s1_q  <= 1'b0;
            a_s2_q  <= 1'b0;
            ck_s1_q <= 1'b0;
            ck_s2_q <= 1'b0;
            ck_s3_q <= 1'b0;
            lt_s1_q <= 1'b0;
            lt_s2_q <= 1'b0;
            lt_s3_q <= 1'b0;
            arm_q   <= 2'd0;
        end else begin
            r1_s1_q <= r1_s1_d;
            r1_s2_q <= r1_s2_d;
            a_s1_q  <= a_s1_d;
            a_s2_q  <= a_s2_d;
            ck_s1_q <= ck_s1_d;
            ck_s2_q <= ck_s2_d;
            ck_s3_q <= ck_s3_d;
            lt_s1_q <= lt_s1_d;
            lt_s2_q <= lt_s2_d;
            lt_s3_q <= lt_s3_d;
            arm_q   <= arm_d;
        end
    end

    // ---------------- shift FSM: state register ----------------
    state_e           state_q, state_d;
    logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            ovr_q     <= 1'b0;
            shreg_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            ovr_q     <= ovr_d;
            shreg_q   <= shreg_d;
        end
    end

    // ---------------- shift FSM: next state ----------------
    // The shift is applied first; *_ps values are the post-shift view the
    // latch decision in the same cycle is evaluated on.
    state_e           state_ps;
    logic             ovr_ps;
    logic [WIDTH-1:0] shreg_ps;

    always_comb begin
        state_ps  = state_q;
        bit_cnt_d = bit_cnt_q;
        ovr_ps    = ovr_q;
        shreg_ps  = shreg_q;
        if (shift_evt) begin
            shreg_ps = {shreg_q[WIDTH-2:0], r1_s2_q};
            case (state_q)
                IDLE, SHIFT: begin
                    bit_cnt_d = bit_cnt_q + BC_W'(1);
                    state_ps  = (bit_cnt_q == BC_W'(WIDTH - 1)) ? FULL : SHIFT;
                end
                default: ovr_ps = 1'b1;
            endcase
        end
        state_d = state_ps;
        ovr_d   = ovr_ps;
        shreg_d = shreg_ps;
        if (latch_evt) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            ovr_d     = 1'b0;
        end
    end

    // ---------------- shift FSM: outputs (latch classification) ----------------
    logic accept, len_evt, ovr_evt;

    always_comb begin
        accept  = 1'b0;
        len_evt = 1'b0;
        ovr_evt = 1'b0;
        if (latch_evt) begin
            if (state_ps != FULL) begin
                len_evt = 1'b1;
            end else if (ovr_ps) begin
                ovr_evt = 1'b1;
            end else begin
                accept = 1'b1;
            end
        end
    end

    // ---------------- row outputs, frame tracking, errors ----------------
    logic [WIDTH-1:0] row_data_q, row_data_d;
    logic             row_addr_q, row_addr_d;
    logic             row_valid_q, row_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             err_len_q, err_len_d, err_ovr_q, err_ovr_d;
    logic             seen0_q, seen0_d, seen1_q, seen1_d;
    logic [CNT_W-1:0] latch_count_q, latch_count_d;

    always_comb begin
        row_data_d    = row_data_q;
        row_addr_d    = row_addr_q;
        row_valid_d   = accept;
        frame_done_d  = 1'b0;
        seen0_d       = seen0_q;
        seen1_d       = seen1_q;
        latch_count_d = latch_count_q;
        if (accept) begin
            row_data_d = shreg_ps;
            row_addr_d = a_s2_q;
            if (a_s2_q) begin
                seen1_d = 1'b1;
            end else begin
                seen0_d = 1'b1;
            end
            if (seen0_d && seen1_d) begin
                frame_done_d = 1'b1;
                seen0_d      = 1'b0;
                seen1_d      = 1'b0;
            end
        end
        if (latch_evt) begin
            latch_count_d = latch_count_q + CNT_W'(1);
        end
        // A new error outranks a simultaneous clear.
        err_len_d = len_evt | (err_len_q & ~clr_err);
        err_ovr_d = ovr_evt | (err_ovr_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_data_q    <= '0;
            row_addr_q    <= 1'b0;
            row_valid_q   <= 1'b0;
            frame_done_q  <= 1'b0;
            seen0_q       <= 1'b0;
            seen1_q       <= 1'b0;
            err_len_q     <= 1'b0;
            err_ovr_q     <= 1'b0;
            latch_count_q <= '0;
        end else begin
            row_data_q    <= row_data_d;
            row_addr_q    <= row_addr_d;
            row_valid_q   <= row_valid_d;
            frame_done_q  <= frame_done_d;
            seen0_q       <= seen0_d;
            seen1_q       <= seen1_d;
            err_len_q     <= err_len_d;
            err_ovr_q     <= err_ovr_d;
            latch_count_q <= latch_count_d;
        end
    end

    assign row_data    = row_data_q;
    assign row_addr    = row_addr_q;
    assign row_valid   = row_valid_q;
    assign frame_done  = frame_done_q;
    assign err_len     = err_len_q;
    assign err_ovr     = err_ovr_q;
    assign latch_count = latch_count_q;

endmodule

// File: tb/tb_led_panel_rx.sv
// Testbench for led_panel_rx: directed corner cases plus randomized rows,
// checked against a bit-counting behavioural model of the panel protocol.
module tb_led_panel_rx;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned PH    = 4;   // clk cycles per clkin/latin phase

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             R1in = 1'b0, Ain = 1'b0, clkin = 1'b0, latin = 1'b0;
    logic             clr_err = 1'b0;
    logic [WIDTH-1:0] row_data;
    logic             row_addr, row_valid, frame_done, err_len, err_ovr;
    logic [CNT_W-1:0] latch_count;

    led_panel_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .R1in(R1in), .Ain(Ain), .clkin(clkin),
        .latin(latin), .clr_err(clr_err), .row_data(row_data),
        .row_addr(row_addr), .row_valid(row_valid), .frame_done(frame_done),
        .err_len(err_len), .err_ovr(err_ovr), .latch_count(latch_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int rv_seen = 0;
    int fd_seen = 0;

    always @(negedge clk) begin
        if (row_valid)  rv_seen++;
        if (frame_done) fd_seen++;
    end

    // behavioural model
    longint unsigned m_sh, m_row;
    bit              m_addr, m_elen, m_eovr, m_s0, m_s1;
    int              m_cnt, m_lc, m_rv, m_fd;
    longint unsigned mask;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_reset();
        m_sh = 0; m_row = 0; m_addr = 0; m_cnt = 0;
        m_elen = 0; m_eovr = 0; m_s0 = 0; m_s1 = 0; m_lc = 0;
    endtask

    task automatic m_shift(input bit b);
        m_sh = ((m_sh << 1) | longint'(b)) & mask;
        m_cnt++;
    endtask

    task automatic m_latch();
        m_lc = (m_lc + 1) % (1 << CNT_W);
        if (m_cnt == WIDTH) begin
            m_row  = m_sh;
            m_addr = Ain;
            m_rv++;
            if (Ain) m_s1 = 1; else m_s0 = 1;
            if (m_s0 && m_s1) begin
                m_fd++;
                m_s0 = 0;
                m_s1 = 0;
            end
        end else if (m_cnt < WIDTH) begin
            m_elen = 1;
        end else begin
            m_eovr = 1;
        end
        m_cnt = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".row_data"},    64'(row_data),    m_row);
        check({tag, ".row_addr"},    64'(row_addr),    64'(m_addr));
        check({tag, ".err_len"},     64'(err_len),     64'(m_elen));
        check({tag, ".err_ovr"},     64'(err_ovr),     64'(m_eovr));
        check({tag, ".latch_count"}, 64'(latch_count), 64'(m_lc));
        check({tag, ".row_valids"},  64'(rv_seen),     64'(m_rv));
        check({tag, ".frame_dones"}, 64'(fd_seen),     64'(m_fd));
    endtask

    task automatic shift_bit(input bit b, input bit with_latch);
        R1in = b;
        wait_cyc(PH);
        clkin = 1'b1;
        if (with_latch) latin = 1'b1;
        wait_cyc(PH);
        clkin = 1'b0;
        latin = 1'b0;
        wait_cyc(PH);
        m_shift(b);
        if (with_latch) m_latch();
    endtask

    task automatic do_latch();
        latin = 1'b1;
        wait_cyc(PH);
        latin = 1'b0;
        wait_cyc(PH);
        m_latch();
    endtask

    task automatic send_row(input string tag, input logic [63:0] data, input int nbits,
                            input bit a, input bit simul);
        Ain = a;
        for (int i = 0; i < nbits; i++) begin
            shift_bit(data[nbits-1-i], simul && (i == nbits - 1));
        end
        if (!simul || nbits == 0) do_latch();
        check_all(tag);
    endtask

    task automatic do_reset(input string tag, input bit hold_high);
        rst_n = 1'b0;
        if (hold_high) begin
            clkin = 1'b1;
            latin = 1'b1;
        end
        wait_cyc(3);
        m_reset();
        check_all({tag, ".in_reset"});
        rst_n = 1'b1;
        wait_cyc(6);
        clkin = 1'b0;
        latin = 1'b0;
        wait_cyc(PH);
        check_all({tag, ".released"});
    endtask

    task automatic pulse_clr(input string tag);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        m_elen = 0;
        m_eovr = 0;
        check({tag, ".err_len"}, 64'(err_len), 64'(m_elen));
        check({tag, ".err_ovr"}, 64'(err_ovr), 64'(m_eovr));
    endtask

    initial begin
        mask = (64'd1 << WIDTH) - 1;
        m_rv = 0;
        m_fd = 0;
        m_reset();

        // reset with clkin/latin held high across release: no false edges
        do_reset("rst0", 1'b1);

        send_row("a5a5", 64'hA5A5_0F0F, WIDTH, 1'b1, 1'b0);
        send_row("row0", 64'h1234_5678, WIDTH, 1'b0, 1'b0);
        send_row("row0_again", 64'h8765_4321, WIDTH, 1'b0, 1'b0);
        send_row("row1", 64'hDEAD_BEEF, WIDTH, 1'b1, 1'b0);

        send_row("short31", 64'h7FFF_0000, WIDTH - 1, 1'b1, 1'b0);
        pulse_clr("clr_len");

        send_row("over33", 64'h1_FFFF_FFFF, WIDTH + 1, 1'b0, 1'b0);
        send_row("after_ovr", 64'hCAFE_F00D, WIDTH, 1'b0, 1'b0);
        pulse_clr("clr_ovr");

        send_row("simul", 64'h0000_0001, WIDTH, 1'b1, 1'b1);

        // reset mid-row after 10 shifts
        Ain = 1'b1;
        for (int i = 0; i < 10; i++) shift_bit(1'b1, 1'b0);
        do_reset("rst_mid", 1'b0);
        send_row("post_rst", 64'h0F1E_2D3C, WIDTH, 1'b1, 1'b0);

        // randomized rows
        for (int r = 0; r < 24; r++) begin
            int unsigned sel;
            int          nb;
            logic [63:0] d;
            sel = $urandom_range(0, 9);
            if (sel == 0)      nb = int'($urandom_range(0, WIDTH - 1));
            else if (sel == 1) nb = int'(WIDTH) + int'($urandom_range(1, 2));
            else               nb = WIDTH;
            d = {$urandom, $urandom};
            send_row($sformatf("rnd%0d", r), d, nb, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) pulse_clr($sformatf("rnd_clr%0d", r));
        end

        // latch_count wrap
        do_reset("rst_wrap", 1'b0);
        for (int i = 0; i < 255; i++) do_latch();
        check_all("lc255");
        do_latch();
        check_all("lc_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/led_panel_rx.md
LED_PANEL_RX -- requirements
Module: led_panel_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 32: number of column bits in one row shift.
REQ-002 SHALL have parameter CNT_W, default 8: width of latch_count.
REQ-003 SHALL have port clk, input, 1: system clock; the only clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port R1in, input, 1: panel serial colour data; asynchronous to clk.
REQ-006 SHALL have port Ain, input, 1: panel row-address bit; asynchronous to clk.
REQ-007 SHALL have port clkin, input, 1: panel shift clock; asynchronous; data sampled on its rising edge.
REQ-008 SHALL have port latin, input, 1: panel latch strobe; asynchronous; acts on its rising edge.
REQ-009 SHALL have port clr_err, input, 1: synchronous clear of the sticky error flags.
REQ-010 SHALL have port row_data, output, WIDTH: last accepted row contents.
REQ-011 SHALL have port row_addr, output, 1: Ain value captured with row_data.
REQ-012 SHALL have port row_valid, output, 1: one-cycle pulse when row_data/row_addr update.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when both rows are accepted.
REQ-014 SHALL have port err_len, output, 1: sticky flag; latch received with a short shift.
REQ-015 SHALL have port err_ovr, output, 1: sticky flag; more than WIDTH shift edges before a latch.
REQ-016 SHALL have port latch_count, output, CNT_W: count of all latin rising edges, wraps.

Function
REQ-017 SHALL pass R1in, Ain, clkin and latin each through a 2-flop synchronizer before any use.
REQ-018 SHALL detect edges from the synchronized signals only, using a third registered copy.
REQ-019 SHALL support clkin and latin high and low phases of at least 3 clk cycles; faster input is out of scope.
REQ-020 SHALL, on each clkin rising edge, shift in the synchronized R1in: shreg <= {shreg[WIDTH-2:0], R1s}.
REQ-021 SHALL keep bit_cnt (range 0..WIDTH) with three states: IDLE (0), SHIFT (1..WIDTH-1) and FULL (WIDTH).
REQ-022 SHALL increment bit_cnt on each shift edge in IDLE or SHIFT.
REQ-023 SHALL, in FULL, continue shifting on shift edges, keep bit_cnt at WIDTH, and set an internal ovr_pending bit.
REQ-024 SHALL, on a latin rising edge with bit_cnt==WIDTH and ovr_pending==0, load row_data<=shreg and row_addr<=As.
REQ-025 SHALL assert row_valid on the cycle after an accepted latch (REQ-024), for exactly one cycle.
REQ-026 SHALL, on a latin rising edge with bit_cnt<WIDTH, leave row_data/row_addr unchanged, give no row_valid, and set err_len.
REQ-027 SHALL, on a latin rising edge with ovr_pending==1, leave outputs unchanged, give no row_valid, and set err_ovr.
REQ-028 SHALL, on every latin rising edge, return bit_cnt to 0 (IDLE), clear ovr_pending and increment latch_count (wrapping 2^CNT_W-1 -> 0).
REQ-029 SHALL, when shift and latch edges are detected in the same cycle, apply the shift first and evaluate the latch on the post-shift shreg/bit_cnt.
REQ-030 SHALL track seen0/seen1 per accepted row_addr, assert frame_done with the row_valid that completes both, then clear both.
REQ-031 SHALL treat a repeat of the same row_addr as a simple overwrite with no frame_done.
REQ-032 SHALL clear err_len/err_ovr one cycle after clr_err is high; a new error in the same cycle as clr_err wins (flag stays set).
REQ-033 SHALL not decode colour or brightness; row_data is raw shifted bits, and the first-shifted bit ends in row_data[WIDTH-1].

Reset
REQ-034 SHALL, while rst_n is low, hold row_data=0, row_addr=0, row_valid=0, frame_done=0, err_len=0, err_ovr=0 and latch_count=0.
REQ-035 SHALL, while rst_n is low, hold bit_cnt=0, shreg=0, ovr_pending=0, seen0=seen1=0, all synchronizer/edge flops at 0.
REQ-036 SHALL discard any partial shift on reset mid-row; after release the first clkin edge is bit 1.
REQ-037 SHALL, if clkin or latin is already high at rst_n release, produce no false edge from the held level.

Verification
REQ-038 SHALL cover: WIDTH=32; shift 0xA5A5_0F0F MSB-first with Ain=1, then latch -> row_data=0xA5A50F0F, row_addr=1, one row_valid, latch_count=1.
REQ-039 SHALL cover: row 0 accepted then row 1 accepted -> frame_done pulses with the second row_valid only; a repeated row 0 -> no frame_done.
REQ-040 SHALL cover: 31 shifts then latch -> err_len=1, row_data unchanged, no row_valid; clr_err -> err_len=0 next cycle.
REQ-041 SHALL cover: 33 shifts then latch -> err_ovr=1, no row_valid; the next clean 32-shift row is accepted normally.
REQ-042 SHALL cover: clkin and latin rising edges in the same cycle on the 32nd bit -> row accepted and includes that bit.
REQ-043 SHALL cover: rst_n pulsed low after 10 shifts -> all outputs 0; next 32 shifts plus latch -> correct row; 256 latches -> latch_count wraps to 0.
